// File: rtl/onehot_grant_decoder.sv
// One-hot grant decoder: latches a 2-bit line index, holds a one-hot grant until
// done or timeout, then inserts a dead cycle. Optional grant counter under GRANT_CNT_EN.
module onehot_grant_decoder #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  in_idx,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [3:0]  grant,
    output logic        grant_valid,
    input  logic        done,
    output logic        timeout,
    output logic [15:0] grant_cnt,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam logic [7:0] LP_WAIT_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_idx;
    logic [7:0]  r_wait;
    logic [3:0]  r_grant;
    logic        r_grant_valid;
    logic        r_timeout;
    logic        w_accept;
    logic        w_tmo_rel;
    logic [1:0]  w_idx_sel;
    logic [3:0]  w_grant_nxt;

    // Handshake: an index transfers on a rising edge where in_valid && in_ready;
    // in_ready is high only in IDLE, and in_idx/in_valid are don't-care elsewhere.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_tmo_rel   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // done takes priority over a simultaneous timeout expiry
                if (done) begin
                    w_state_nxt = ST_GAP;
                end else if (r_wait == LP_WAIT_LAST) begin
                    w_tmo_rel   = 1'b1;
                    w_state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_idx_sel   = w_accept ? in_idx : r_idx;
    assign w_grant_nxt = (w_state_nxt == ST_GRANT) ? (4'b0001 << w_idx_sel) : 4'b0000;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_idx         <= 2'd0;
            r_wait        <= 8'd0;
            r_grant       <= 4'b0000;
            r_grant_valid <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_grant       <= w_grant_nxt;
            r_grant_valid <= (w_state_nxt == ST_GRANT);
            r_timeout     <= w_tmo_rel;
            if (w_accept) begin
                r_idx  <= in_idx;
                r_wait <= 8'd0;
            end else if (r_state == ST_GRANT && !done) begin
                r_wait <= r_wait + 8'd1;
            end
        end
    end

`ifdef GRANT_CNT_EN
    logic [15:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 16'h0000;
        end else if (w_accept) begin
            r_cnt <= r_cnt + 16'h0001;
        end
    end

    assign grant_cnt = r_cnt;
`else
    assign grant_cnt = 16'h0000;
`endif

    assign in_ready    = (r_state == ST_IDLE);
    assign grant       = r_grant;
    assign grant_valid = r_grant_valid;
    assign timeout     = r_timeout;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_onehot_grant_decoder.sv
// Directed bench for onehot_grant_decoder: vector table for grant/release cases
// plus hand-written reset, busy-ignore and back-to-back sequences.
module tb_onehot_grant_decoder;

    logic        clk;
    logic        rst_n;
    logic [1:0]  in_idx;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  grant;
    logic        grant_valid;
    logic        done;
    logic        timeout;
    logic [15:0] grant_cnt;
    logic [1:0]  dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_cnt = 0;

    onehot_grant_decoder #(.TIMEOUT(15)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_idx      (in_idx),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .grant       (grant),
        .grant_valid (grant_valid),
        .done        (done),
        .timeout     (timeout),
        .grant_cnt   (grant_cnt),
        .dbg_state   (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [1:0] idx;
        int         done_at;   // GRANT cycle on which done is raised; 0 = never
        int         exp_len;   // expected number of cycles grant is held
        logic [3:0] exp_grant;
        logic       exp_tmo;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] cnt_exp();
`ifdef GRANT_CNT_EN
        return 16'(exp_cnt);
`else
        return 16'h0000;
`endif
    endfunction

    // Runs one grant from IDLE through GAP back to IDLE.
    task automatic run_vec(input vec_t v, input string tag);
        int c;
        logic [3:0] g_err;
        check({tag, " idle_ready"}, 32'(in_ready), 32'd1);
        check({tag, " idle_grant"}, 32'(grant), 32'd0);
        in_idx   = v.idx;
        in_valid = 1'b1;
        tick();
        exp_cnt++;
        in_valid = 1'b0;
        in_idx   = 2'($urandom_range(0, 3));
        c     = 0;
        g_err = 4'b0000;
        while (grant_valid && c < 300) begin
            c++;
            if (grant !== v.exp_grant) g_err = grant;
            if (in_ready !== 1'b0 || timeout !== 1'b0) g_err = 4'hF;
            if (c == v.done_at) done = 1'b1;
            in_valid = 1'($urandom_range(0, 1));
            tick();
            done     = 1'b0;
            in_valid = 1'b0;
        end
        check({tag, " grant_value_err"}, 32'(g_err), 32'd0);
        check({tag, " grant_len"}, 32'(c), 32'(v.exp_len));
        check({tag, " gap_grant"}, 32'(grant), 32'd0);
        check({tag, " gap_ready"}, 32'(in_ready), 32'd0);
        check({tag, " gap_timeout"}, 32'(timeout), 32'(v.exp_tmo));
        tick();
        check({tag, " back_idle_ready"}, 32'(in_ready), 32'd1);
        check({tag, " back_idle_tmo"}, 32'(timeout), 32'd0);
        check({tag, " cnt"}, 32'(grant_cnt), 32'(cnt_exp()));
    endtask

    initial begin
        vecs[0] = '{idx: 2'd0, done_at: 2,  exp_len: 2,  exp_grant: 4'b0001, exp_tmo: 1'b0};
        vecs[1] = '{idx: 2'd1, done_at: 2,  exp_len: 2,  exp_grant: 4'b0010, exp_tmo: 1'b0};
        vecs[2] = '{idx: 2'd2, done_at: 2,  exp_len: 2,  exp_grant: 4'b0100, exp_tmo: 1'b0};
        vecs[3] = '{idx: 2'd3, done_at: 2,  exp_len: 2,  exp_grant: 4'b1000, exp_tmo: 1'b0};
        vecs[4] = '{idx: 2'd3, done_at: 0,  exp_len: 15, exp_grant: 4'b1000, exp_tmo: 1'b1};
        vecs[5] = '{idx: 2'd2, done_at: 15, exp_len: 15, exp_grant: 4'b0100, exp_tmo: 1'b0};
        vecs[6] = '{idx: 2'd1, done_at: 14, exp_len: 14, exp_grant: 4'b0010, exp_tmo: 1'b0};
        vecs[7] = '{idx: 2'd0, done_at: 1,  exp_len: 1,  exp_grant: 4'b0001, exp_tmo: 1'b0};

        rst_n    = 1'b0;
        in_idx   = 2'd2;
        in_valid = 1'b1;
        done     = 1'b0;
        tick();
        tick();
        check("reset_grant", 32'(grant), 32'd0);
        check("reset_grant_valid", 32'(grant_valid), 32'd0);
        check("reset_timeout", 32'(timeout), 32'd0);
        check("reset_cnt", 32'(grant_cnt), 32'd0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        check("reset_release_ready", 32'(in_ready), 32'd1);

        // done outside GRANT is ignored
        done = 1'b1;
        tick();
        tick();
        done = 1'b0;
        check("idle_done_ignored_ready", 32'(in_ready), 32'd1);
        check("idle_done_ignored_grant", 32'(grant), 32'd0);

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Busy ignore and back-to-back with in_valid held high
        in_idx   = 2'd0;
        in_valid = 1'b1;
        tick();
        exp_cnt++;
        for (int i = 0; i < 4; i++) begin
            in_idx = 2'(i);
            check($sformatf("busy_grant%0d", i), 32'(grant), 32'b0001);
            check($sformatf("busy_ready%0d", i), 32'(in_ready), 32'd0);
            tick();
        end
        in_idx = 2'd3;
        done   = 1'b1;
        tick();
        done = 1'b0;
        check("b2b_gap_grant", 32'(grant), 32'd0);
        check("b2b_gap_valid", 32'(grant_valid), 32'd0);
        check("b2b_gap_ready", 32'(in_ready), 32'd0);
        tick();
        check("b2b_idle_ready", 32'(in_ready), 32'd1);
        check("b2b_idle_grant", 32'(grant), 32'd0);
        tick();
        exp_cnt++;
        in_valid = 1'b0;
        check("b2b_second_grant", 32'(grant), 32'b1000);
        check("b2b_cnt", 32'(grant_cnt), 32'(cnt_exp()));
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();

        // Asynchronous reset mid-GRANT, then acceptance on the first edge after release
        in_idx   = 2'd2;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("pre_reset_grant", 32'(grant), 32'b0100);
        #2;
        rst_n = 1'b0;
        #1;
        exp_cnt = 0;
        check("async_reset_grant", 32'(grant), 32'd0);
        check("async_reset_valid", 32'(grant_valid), 32'd0);
        check("async_reset_cnt", 32'(grant_cnt), 32'd0);
        tick();
        rst_n = 1'b1;
        check("post_reset_ready", 32'(in_ready), 32'd1);
        in_idx   = 2'd1;
        in_valid = 1'b1;
        tick();
        exp_cnt++;
        in_valid = 1'b0;
        check("first_accept_grant", 32'(grant), 32'b0010);
        check("first_accept_cnt", 32'(grant_cnt), 32'(cnt_exp()));
        done = 1'b1;
        tick();
        done = 1'b0;
        check("first_accept_gap_tmo", 32'(timeout), 32'd0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
